dma_c2h_arbiter: RTL
====================

# dma_c2h_arbiter

Round-robin, packet-granular arbiter that shares the single XDMA C2H AXI-Stream channel (`m_axis_c2h_*`) among `NUM_SRC` producer streams in the `m_axis_c2h_aclk` domain. It sits between the capture/producer blocks inside `simulation_top` and the XDMA IP. Grants are held for a whole packet (until `tlast`). Packet length is bounded by a beat limit, and the block exposes grant and packet statistics for debug.

## Interface
- `NUM_SRC`, 4: number of requesting streams (2..8).
- `DATA_W`, 512: stream data width in bits (multiple of 64).
- `MAX_BEATS`, 256: maximum beats per granted packet (power of two, ≥2).
- `m_axis_c2h_aclk` in 1: the only clock.
- `rstn_en` in 1: asynchronous, active-low reset.
- `arb_enable` in 1: when low, no new grant is issued. A packet already in progress completes.
- `s_tdata` in NUM_SRC*DATA_W: source data; source i occupies bits [i*DATA_W +: DATA_W].
- `s_tvalid` in NUM_SRC: per-source valid.
- `s_tlast` in NUM_SRC: per-source end of packet.
- `s_tready` out NUM_SRC: per-source ready.
- `m_axis_c2h_tdata_0` out DATA_W: data to XDMA.
- `m_axis_c2h_tkeep_0` out DATA_W/8: byte enables; always all ones.
- `m_axis_c2h_tlast_0` out 1: end of packet.
- `m_axis_c2h_tvalid_0` out 1: valid.
- `m_axis_c2h_tready_0` in 1: XDMA ready.
- `cur_src` out 3: index of the granted source. Holds the last granted index when idle.
- `busy` out 1: high while in HDR or DATA.
- `pkt_cnt` out 32: number of completed output packets, wraps at 2^32.
- `len_err` out 1: sticky flag, set when a packet is truncated at MAX_BEATS.

## Operation
- **States:** IDLE, HDR (only with tag enabled), DATA.
- **IDLE:**
  - If `arb_enable` is high and any `s_tvalid` is high, grant the first requester searching from `rr_ptr+1` modulo NUM_SRC.
  - On grant: latch the index into `cur_src`, set `rr_ptr` to that index, clear the beat counter, and go to HDR (tag enabled) or DATA.
  - No grant is issued without a valid request.
- **DATA:**
  - `m_axis_c2h_tdata_0` = granted source's `s_tdata`.
  - `m_axis_c2h_tvalid_0` = `s_tvalid[cur_src]`.
  - `s_tready[cur_src]` = `m_axis_c2h_tready_0`.
  - `s_tready` for all other sources = 0.
  - The beat counter increments on each output handshake.
- **Packet end:** on a handshake with `s_tlast[cur_src]` high, or with the beat counter at MAX_BEATS-1:
  - `m_axis_c2h_tlast_0` = 1, `pkt_cnt` increments, and the state returns to IDLE.
  - The forced case (beat counter at limit without `s_tlast`) sets `len_err`. The source's remaining beats are arbitrated later as a new packet.
- **Fairness:** after source k completes, source k has lowest priority in the next arbitration.
- **Counter width:** the beat counter is clog2(MAX_BEATS) bits and never wraps within a packet.
- **`arb_enable` deasserted in DATA:** no effect until the packet ends.

## Timing
- **Reset values:**
  - State IDLE, `rr_ptr` = NUM_SRC-1 (so source 0 wins first).
  - `cur_src` = 0, `busy` = 0, `pkt_cnt` = 0, `len_err` = 0.
  - All `s_tready` = 0, `m_axis_c2h_tvalid_0` = 0, `m_axis_c2h_tlast_0` = 0, `m_axis_c2h_tdata_0` = 0.
- **Latency:** a request seen in IDLE at cycle N is granted at edge N+1. The first beat (header or data) is presentable from cycle N+1. There is one dead cycle in IDLE between back-to-back packets.
- **Handshake:** the transfer occurs when tvalid and tready are both high at a rising edge.
  - `m_axis_c2h_tvalid_0` never depends combinationally on `m_axis_c2h_tready_0`.
  - The source holds data and valid stable while stalled. The arbiter forwards them unchanged, so AXI stability is preserved.
- **Simultaneous requests:** handled by round robin only. The order of `tvalid` assertion has no effect.
- **Reset mid-packet:** outputs drop immediately (asynchronously). The partial packet is abandoned, with no tlast emitted.
- **Source drops `s_tvalid` mid-packet:** the grant is held and the output stalls. There is no timeout.

## Configuration
- **Macro:** `C2H_SRC_TAG_EN`.
- **Defined:** each packet is preceded by one header beat, emitted in HDR.
  - Header fields: `tdata[7:0]` = 8'hA5, `[15:8]` = source index, `[31:16]` = 16-bit header sequence number, remaining bits 0.
  - Header beat: `tkeep` all ones, `tlast` 0, all `s_tready` = 0.
  - The sequence number increments on each header handshake and resets to 0.
  - The header does not count toward MAX_BEATS.
- **Undefined:** no HDR state; IDLE goes directly to DATA and the output packets are exactly the source beats.

## Test plan
- **Single source:** reset, then source 0 sends 4 beats 0x1..0x4 with tlast on 0x4 and tready held high. Expect 4 output beats in order, tlast on beat 4, `pkt_cnt` = 1 and `cur_src` = 0. With `C2H_SRC_TAG_EN`, a header 0x0000_00A5 precedes them.
- **All sources requesting:** all 4 sources continuously send 2-beat packets. The grant order is 0,1,2,3,0,… and `pkt_cnt` = 8 after 8 packets.
- **Backpressure:** toggle `m_axis_c2h_tready_0` every cycle during a 16-beat packet. The output data sequence is unchanged, `s_tready` mirrors tready, and no beat is dropped or duplicated.
- **Truncation:** with MAX_BEATS = 4, a source sends 6 beats with tlast on beat 6. Expect output tlast on beat 4 and `len_err` = 1, then beats 5–6 as the next packet with `pkt_cnt` = 2.
- **`arb_enable` = 0:**
  - Low while source 1 requests: no grant and `busy` = 0.
  - Deasserted mid-packet: the current packet completes, then the block stays in IDLE.
- **Reset mid-packet:** assert `rstn_en` = 0 at beat 2. All outputs return to reset values in the same cycle. After release, source 0 is granted first.

Source files
------------

// File: rtl/dma_c2h_arbiter.sv
// dma_c2h_arbiter: packet-granular round-robin arbiter feeding the XDMA C2H AXI-Stream channel.
// Define C2H_SRC_TAG_EN to precede every packet with a source/sequence header beat.
module dma_c2h_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 512,
    parameter int MAX_BEATS = 256
) (
    input  logic                      m_axis_c2h_aclk,
    input  logic                      rstn_en,
    input  logic                      arb_enable,
    input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]        s_tvalid,
    input  logic [NUM_SRC-1:0]        s_tlast,
    output logic [NUM_SRC-1:0]        s_tready,
    output logic [DATA_W-1:0]         m_axis_c2h_tdata_0,
    output logic [DATA_W/8-1:0]       m_axis_c2h_tkeep_0,
    output logic                      m_axis_c2h_tlast_0,
    output logic                      m_axis_c2h_tvalid_0,
    input  logic                      m_axis_c2h_tready_0,
    output logic [2:0]                cur_src,
    output logic                      busy,
    output logic [31:0]               pkt_cnt,
    output logic                      len_err,
    output logic [1:0]                fsm_state
);
    localparam int CNT_W = $clog2(MAX_BEATS);

`ifdef C2H_SRC_TAG_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_t;
    logic [15:0] hdr_seq;
    logic        hdr_hs;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2} state_t;
`endif

    // Valid/ready: a beat moves on a rising edge where tvalid and tready are both high;
    // tvalid never depends on tready, and a stalled source's beat is forwarded unchanged.
    state_t               state, state_nxt;
    logic [2:0]           rr_ptr;
    logic [CNT_W-1:0]     beat_cnt;
    logic [NUM_SRC-1:0]   req_rot;
    logic [3:0]           rot_base, grant_sum;
    logic [2:0]           grant_off, grant_idx;
    logic                 grant_vld, grant_go;
    logic                 data_hs, pkt_end, at_limit;
    logic [7:0]           valid8, last8, ready8;
    logic [DATA_W-1:0]    data8 [8];

    // Per-source views padded to 8 entries so cur_src indexes them directly.
    always_comb begin
        valid8 = '0;
        last8  = '0;
        for (int i = 0; i < 8; i++) data8[i] = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            valid8[i] = s_tvalid[i];
            last8[i]  = s_tlast[i];
            data8[i]  = s_tdata[i*DATA_W +: DATA_W];
        end
    end

    // Rotate requests so bit 0 is the source just after rr_ptr; the lowest set bit wins.
    always_comb begin
        rot_base  = {1'b0, rr_ptr} + 4'd1;
        req_rot   = NUM_SRC'({s_tvalid, s_tvalid} >> rot_base);
        grant_vld = |req_rot;
        grant_off = '0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (req_rot[j]) grant_off = 3'(j);
        end
        grant_sum = rot_base + {1'b0, grant_off};
        grant_idx = 3'(32'(grant_sum) % NUM_SRC);
        grant_go  = arb_enable & grant_vld;
    end

    always_comb begin
        state_nxt           = state;
        m_axis_c2h_tvalid_0 = 1'b0;
        m_axis_c2h_tdata_0  = '0;
        m_axis_c2h_tlast_0  = 1'b0;
        ready8              = '0;
        data_hs             = 1'b0;
        pkt_end             = 1'b0;
        at_limit            = (beat_cnt == CNT_W'(MAX_BEATS - 1));
`ifdef C2H_SRC_TAG_EN
        hdr_hs              = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef C2H_SRC_TAG_EN
                if (grant_go) state_nxt = HDR;
`else
                if (grant_go) state_nxt = DATA;
`endif
            end
`ifdef C2H_SRC_TAG_EN
            HDR: begin
                m_axis_c2h_tvalid_0       = 1'b1;
                m_axis_c2h_tdata_0[31:0]  = {hdr_seq, 5'd0, cur_src, 8'hA5};
                hdr_hs                    = m_axis_c2h_tready_0;
                if (m_axis_c2h_tready_0) state_nxt = DATA;
            end
`endif
            DATA: begin
                m_axis_c2h_tvalid_0 = valid8[cur_src];
                m_axis_c2h_tdata_0  = data8[cur_src];
                m_axis_c2h_tlast_0  = last8[cur_src] | at_limit;
                ready8              = 8'(m_axis_c2h_tready_0) << cur_src;
                data_hs             = valid8[cur_src] & m_axis_c2h_tready_0;
                pkt_end             = data_hs & m_axis_c2h_tlast_0;
                if (pkt_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge m_axis_c2h_aclk or negedge rstn_en) begin
        if (!rstn_en) begin
            state    <= IDLE;
            rr_ptr   <= 3'(NUM_SRC - 1);
            cur_src  <= '0;
            beat_cnt <= '0;
            pkt_cnt  <= '0;
            len_err  <= 1'b0;
`ifdef C2H_SRC_TAG_EN
            hdr_seq  <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_go) begin
                cur_src  <= grant_idx;
                rr_ptr   <= grant_idx;
                beat_cnt <= '0;
            end else if (data_hs && !pkt_end) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            // A forced end without source tlast means the packet was truncated.
            if (pkt_end) begin
                pkt_cnt <= pkt_cnt + 32'd1;
                if (!last8[cur_src]) len_err <= 1'b1;
            end
`ifdef C2H_SRC_TAG_EN
            if (hdr_hs) hdr_seq <= hdr_seq + 16'd1;
`endif
        end
    end

    assign s_tready           = ready8[NUM_SRC-1:0];
    assign m_axis_c2h_tkeep_0 = '1;
    assign busy               = (state != IDLE);
    assign fsm_state          = state;

endmodule
